// File: rtl/fifo_vc_arbiter_pkg.sv
// Shared definitions for the virtual-channel FIFO arbiter: FSM encoding,
// default FIFO thresholds and default geometry.
package fifo_vc_arbiter_pkg;

    localparam int unsigned NUM_VC_DEF    = 4;
    localparam int unsigned WORD_SIZE_DEF = 10;
    localparam int unsigned PTR_SIZE_DEF  = 3;
    localparam int unsigned VC_BITS_DEF   = 2;

    localparam int unsigned UMBRAL_AE_DEF = 2;
    localparam int unsigned UMBRAL_AF_DEF = 6;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_vc_arbiter_if.sv
// Handshake bundle between the arbiter, the input VC FIFOs and the output FIFO.
interface fifo_vc_arbiter_if
    import fifo_vc_arbiter_pkg::*;
#(
    parameter int unsigned NUM_VC    = NUM_VC_DEF,
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) ();

    logic [NUM_VC-1:0]           vc_empty;
    logic [NUM_VC*WORD_SIZE-1:0] vc_data;
    logic [NUM_VC-1:0]           vc_rd_en;
    logic                        out_full;
    logic                        out_almost_full;
    logic                        out_wr_en;
    logic [WORD_SIZE-1:0]        out_data;

    modport master (
        input  vc_empty, vc_data, out_full, out_almost_full,
        output vc_rd_en, out_wr_en, out_data
    );

    modport slave (
        output vc_empty, vc_data, out_full, out_almost_full,
        input  vc_rd_en, out_wr_en, out_data
    );

endinterface

// File: rtl/fifo_vc_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester after last_grant wins,
// last_grant itself has lowest priority.
module rr_priority_picker
    import fifo_vc_arbiter_pkg::*;
#(
    parameter int unsigned NUM_VC  = NUM_VC_DEF,
    parameter int unsigned VC_BITS = VC_BITS_DEF
) (
    input  logic [NUM_VC-1:0]  req,
    input  logic [VC_BITS-1:0] last_grant,
    output logic [NUM_VC-1:0]  grant,
    output logic [VC_BITS-1:0] grant_idx,
    output logic               grant_valid
);

    logic [VC_BITS-1:0] idx;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            idx = last_grant + VC_BITS'(NUM_VC - k);
            if (req[idx]) begin
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_vc_arbiter.sv
// Round-robin drain of NUM_VC input FIFOs into one output FIFO, plus the
// FIFO configuration (thresholds, init strobe) owned by this block.
module fifo_vc_arbiter
    import fifo_vc_arbiter_pkg::*;
#(
    parameter int unsigned NUM_VC    = NUM_VC_DEF,
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned PTR_SIZE  = PTR_SIZE_DEF,
    parameter int unsigned VC_BITS   = VC_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [PTR_SIZE-1:0]  umbral_ae_in,
    input  logic [PTR_SIZE-1:0]  umbral_af_in,
    fifo_vc_arbiter_if.master    bus,
    output logic                 fifo_init,
    output logic [PTR_SIZE-1:0]  umbral_ae,
    output logic [PTR_SIZE-1:0]  umbral_af,
    output logic [1:0]           state,
    output logic [VC_BITS-1:0]   last_grant,
    output logic                 error
);

    state_t             state_q, state_d;
    logic               ready;
    logic               pop;
    logic [NUM_VC-1:0]  req;
    logic [NUM_VC-1:0]  pick_onehot;
    logic [VC_BITS-1:0] pick_idx;
    logic               pick_valid;
    logic               pend_valid;
    logic [VC_BITS-1:0] pend_idx;

    assign ready = !bus.out_full && !bus.out_almost_full;
    assign req   = ~bus.vc_empty;

    rr_priority_picker #(
        .NUM_VC  (NUM_VC),
        .VC_BITS (VC_BITS)
    ) u_picker (
        .req         (req),
        .last_grant  (last_grant),
        .grant       (pick_onehot),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // init wins over a pending pop in both IDLE and ACTIVE.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (init) state_d = ST_INIT;
                else if (ready && pick_valid) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init) state_d = ST_INIT;
                else if (ready && pick_valid) pop = 1'b1;
                else state_d = ST_IDLE;
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign bus.vc_rd_en = pop ? pick_onehot : '0;
    assign fifo_init    = (state_q == ST_INIT);
    assign state        = state_q;

    // Input FIFO data shows up the cycle after rd_en, so the push mux uses the
    // pipelined grant index against live vc_data rather than a registered word.
    assign bus.out_wr_en = pend_valid;
    assign bus.out_data  = pend_valid ? bus.vc_data[pend_idx*WORD_SIZE +: WORD_SIZE] : '0;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            last_grant <= VC_BITS'(NUM_VC - 1);
            error      <= 1'b0;
        end else begin
            pend_valid <= pop;
            if (pop) begin
                pend_idx   <= pick_idx;
                last_grant <= pick_idx;
            end
            if (pend_valid && bus.out_full) begin
                error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            umbral_ae <= PTR_SIZE'(UMBRAL_AE_DEF);
            umbral_af <= PTR_SIZE'(UMBRAL_AF_DEF);
        end else if (state_q == ST_INIT) begin
            umbral_ae <= umbral_ae_in;
            umbral_af <= umbral_af_in;
        end
    end

endmodule

// File: tb/tb_fifo_vc_arbiter.sv
// Directed bench for fifo_vc_arbiter: simple input-FIFO stubs, pop/push logs
// and hand-computed expected sequences.
module tb_fifo_vc_arbiter;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [2:0] umbral_ae_in;
    logic [2:0] umbral_af_in;
    logic       fifo_init;
    logic [2:0] umbral_ae;
    logic [2:0] umbral_af;
    logic [1:0] state;
    logic [1:0] last_grant;
    logic       error;

    fifo_vc_arbiter_if #(.NUM_VC(4), .WORD_SIZE(10)) bus ();

    fifo_vc_arbiter #(
        .NUM_VC    (4),
        .WORD_SIZE (10),
        .PTR_SIZE  (3),
        .VC_BITS   (2)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .umbral_ae_in (umbral_ae_in),
        .umbral_af_in (umbral_af_in),
        .bus          (bus),
        .fifo_init    (fifo_init),
        .umbral_ae    (umbral_ae),
        .umbral_af    (umbral_af),
        .state        (state),
        .last_grant   (last_grant),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input FIFO stubs: word appears on vc_data the cycle after its rd_en.
    logic [9:0] mem [4][16];
    int         wr_ptr [4] = '{0, 0, 0, 0};
    int         rd_ptr [4] = '{0, 0, 0, 0};
    logic [9:0] data_q [4] = '{10'h0, 10'h0, 10'h0, 10'h0};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.vc_rd_en[i]) begin
                data_q[i] <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        bus.vc_empty = '0;
        bus.vc_data  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.vc_empty[i]        = (rd_ptr[i] == wr_ptr[i]);
            bus.vc_data[i*10 +: 10] = data_q[i];
        end
    end

    int         cyc = 0;
    int         pop_log[$];
    int         pop_cyc[$];
    logic [9:0] push_log[$];

    always @(negedge clk) begin
        #4;
        cyc = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (bus.vc_rd_en[i]) begin
                pop_log.push_back(i);
                pop_cyc.push_back(cyc);
            end
        end
        if (bus.out_wr_en) push_log.push_back(bus.out_data);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int vc, input logic [9:0] w);
        mem[vc][wr_ptr[vc]] = w;
        wr_ptr[vc] = wr_ptr[vc] + 1;
    endtask

    function automatic int pop_at(input int k);
        return (k < pop_log.size()) ? pop_log[k] : -1;
    endfunction

    function automatic int popc_at(input int k);
        return (k < pop_cyc.size()) ? pop_cyc[k] : -1;
    endfunction

    function automatic logic [31:0] push_at(input int k);
        return (k < push_log.size()) ? 32'(push_log[k]) : 32'hFFFF_FFFF;
    endfunction

    task automatic check_seq(input string tag, input int pb, input int qb, input int n,
                             input int exp_pop[12], input logic [9:0] exp_push[12]);
        check({tag, "_npop"}, pop_log.size() - pb, n);
        check({tag, "_npush"}, push_log.size() - qb, n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_pop%0d", tag, k), pop_at(pb + k), exp_pop[k]);
            check($sformatf("%s_push%0d", tag, k), push_at(qb + k), 32'(exp_push[k]));
        end
    endtask

    int         pb, qb;
    int         e_pop [12];
    logic [9:0] e_push [12];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_L             = 1'b0;
        init                = 1'b0;
        umbral_ae_in        = 3'd2;
        umbral_af_in        = 3'd6;
        bus.out_full        = 1'b0;
        bus.out_almost_full = 1'b0;

        // Reset values
        step();
        step();
        check("rst_state", state, 0);
        check("rst_ae", umbral_ae, 2);
        check("rst_af", umbral_af, 6);
        check("rst_rd_en", bus.vc_rd_en, 0);
        check("rst_wr_en", bus.out_wr_en, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_finit", fifo_init, 0);
        check("rst_error", error, 0);
        check("rst_lgrant", last_grant, 3);

        reset_L = 1'b1;
        step();
        check("boot_state_init", state, 1);
        check("boot_finit", fifo_init, 1);
        step();
        check("boot_state_idle", state, 2);
        check("boot_ae", umbral_ae, 2);
        check("boot_af", umbral_af, 6);
        check("boot_rd_en", bus.vc_rd_en, 0);

        // Configuration
        init         = 1'b1;
        umbral_ae_in = 3'd1;
        umbral_af_in = 3'd5;
        step();
        check("cfg_state1", state, 1);
        check("cfg_finit1", fifo_init, 1);
        step();
        check("cfg_state2", state, 1);
        check("cfg_rd_en", bus.vc_rd_en, 0);
        init = 1'b0;
        step();
        check("cfg_state_idle", state, 2);
        check("cfg_finit0", fifo_init, 0);
        check("cfg_ae", umbral_ae, 1);
        check("cfg_af", umbral_af, 5);

        // Round-robin fairness: 3 words per VC
        pb = pop_log.size();
        qb = push_log.size();
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 4; i++)
                load(i, 10'(i * 16 + j));
        e_pop  = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        e_push = '{10'h00, 10'h10, 10'h20, 10'h30, 10'h01, 10'h11,
                   10'h21, 10'h31, 10'h02, 10'h12, 10'h22, 10'h32};
        repeat (20) step();
        check_seq("rr", pb, qb, 12, e_pop, e_push);
        for (int k = 1; k < 12; k++)
            check($sformatf("rr_b2b%0d", k), popc_at(pb + k) - popc_at(pb), k);
        check("rr_state", state, 2);
        check("rr_lgrant", last_grant, 3);
        check("rr_error", error, 0);

        // Sparse: only VC2, two words
        pb = pop_log.size();
        qb = push_log.size();
        load(2, 10'h23);
        load(2, 10'h24);
        e_pop  = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e_push = '{10'h23, 10'h24, 10'h0, 10'h0, 10'h0, 10'h0,
                   10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0};
        repeat (8) step();
        check_seq("sp", pb, qb, 2, e_pop, e_push);
        check("sp_b2b", popc_at(pb + 1) - popc_at(pb), 1);
        check("sp_state", state, 2);
        check("sp_lgrant", last_grant, 2);

        // Back-pressure via out_almost_full
        pb = pop_log.size();
        qb = push_log.size();
        load(3, 10'h33); load(3, 10'h34);
        load(0, 10'h03); load(0, 10'h04);
        load(1, 10'h13); load(1, 10'h14);
        load(2, 10'h25); load(2, 10'h26);
        step();
        check("bp_state_act", state, 3);
        check("bp_rd_en_vc3", bus.vc_rd_en, 4'b1000);
        step();
        check("bp_rd_en_vc0", bus.vc_rd_en, 4'b0001);
        check("bp_wr_en", bus.out_wr_en, 1);
        check("bp_data", bus.out_data, 10'h33);
        bus.out_almost_full = 1'b1;
        #1;
        check("bp_af_rd_en", bus.vc_rd_en, 0);
        check("bp_af_inflight", bus.out_wr_en, 1);
        step();
        check("bp_af_state", state, 2);
        check("bp_af_rd_en2", bus.vc_rd_en, 0);
        check("bp_af_wr_en", bus.out_wr_en, 0);
        bus.out_almost_full = 1'b0;
        step();
        check("bp_resume_state", state, 3);
        check("bp_resume_rd_en", bus.vc_rd_en, 4'b0001);
        check("bp_resume_lgrant", last_grant, 3);
        e_pop  = '{3, 0, 1, 2, 3, 0, 1, 2, 0, 0, 0, 0};
        e_push = '{10'h33, 10'h03, 10'h13, 10'h25, 10'h34, 10'h04,
                   10'h14, 10'h26, 10'h0, 10'h0, 10'h0, 10'h0};
        repeat (12) step();
        check_seq("bp", pb, qb, 8, e_pop, e_push);
        check("bp_lgrant", last_grant, 2);

        // Overflow error while a word is in flight
        load(0, 10'h05);
        step();
        check("err_rd_en", bus.vc_rd_en, 4'b0001);
        step();
        check("err_wr_en", bus.out_wr_en, 1);
        check("err_data", bus.out_data, 10'h05);
        check("err_pre", error, 0);
        bus.out_full = 1'b1;
        #1;
        check("err_inflight", bus.out_wr_en, 1);
        step();
        check("err_set", error, 1);
        bus.out_full = 1'b0;
        repeat (3) step();
        check("err_sticky", error, 1);
        check("err_state", state, 2);

        // init asserted during ACTIVE
        pb = pop_log.size();
        qb = push_log.size();
        load(1, 10'h15);
        load(1, 10'h16);
        load(1, 10'h17);
        umbral_ae_in = 3'd2;
        umbral_af_in = 3'd6;
        step();
        check("mi_state_act", state, 3);
        check("mi_rd_en", bus.vc_rd_en, 4'b0010);
        step();
        check("mi_wr_en", bus.out_wr_en, 1);
        init = 1'b1;
        #1;
        check("mi_init_rd_en", bus.vc_rd_en, 0);
        check("mi_pending_wr", bus.out_wr_en, 1);
        check("mi_pending_data", bus.out_data, 10'h15);
        step();
        check("mi_state_init", state, 1);
        check("mi_finit", fifo_init, 1);
        check("mi_rd_en_init", bus.vc_rd_en, 0);
        check("mi_wr_en_init", bus.out_wr_en, 0);
        check("mi_ae_old", umbral_ae, 1);
        init = 1'b0;
        step();
        check("mi_state_idle", state, 2);
        check("mi_ae_new", umbral_ae, 2);
        check("mi_af_new", umbral_af, 6);
        e_pop  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e_push = '{10'h15, 10'h16, 10'h17, 10'h0, 10'h0, 10'h0,
                   10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0};
        repeat (8) step();
        check_seq("mi", pb, qb, 3, e_pop, e_push);
        check("mi_lgrant", last_grant, 1);
        check("mi_state_end", state, 2);
        check("mi_error_end", error, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
